dec_onehot_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes and a scan mode that walks the active bit across successive outputs. It is the next-generation select decoder for multi-target enables, such as bank select, channel strobe and round-robin polling. A single transaction either decodes one code or emits a burst of walking-one words with wrap-around. Out-of-range codes on non-power-of-two widths are detected and flagged.

---
 rtl/dec_pkg.sv | 15 +
 rtl/dec_onehot_comb.sv | 19 +
 rtl/dec_onehot_seq.sv | 126 ++++++++++++
 tb/tb_dec_onehot_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types for the one-hot select decoder: request mode and sequencer states.
package dec_pkg;

  typedef enum logic {
    DEC_MODE_DECODE = 1'b0,
    DEC_MODE_SCAN   = 1'b1
  } dec_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_SCAN
  } dec_state_e;

endpackage

// File: rtl/dec_onehot_comb.sv
// Combinational code-to-one-hot decode; codes at or above NUM_OUT yield zeros and range_err.
module dec_onehot_comb #(
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
  input  logic [SEL_W-1:0]   code,
  output logic [NUM_OUT-1:0] onehot,
  output logic               range_err
);

  always_comb begin
    onehot    = '0;
    range_err = 32'(code) >= NUM_OUT;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      onehot[i] = (32'(code) == i);
    end
  end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with valid/ready handshakes and a wrapping walking-one scan mode.
// Define DEC_ERR_STICKY_EN to make err sticky until err_clr or reset.
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT),
  parameter int unsigned LEN_W   = SEL_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_mode,
  input  logic [LEN_W-1:0]   in_len,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
  input  logic               err_clr
);

  dec_state_e         state_q, state_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic [SEL_W-1:0]   cur_q, cur_d, cur_inc, dec_code;
  logic [LEN_W-1:0]   rem_q, rem_d, len_m1;
  logic               err_beat_q, err_beat_d;
  logic [NUM_OUT-1:0] dec_word;
  logic               dec_err;
  logic               accept, consume;

  assign out_valid = (state_q != S_IDLE);
  assign in_ready  = (state_q != S_SCAN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  assign cur_inc  = (cur_q == SEL_W'(NUM_OUT - 1)) ? '0 : cur_q + SEL_W'(1);
  // No accept can happen in S_SCAN, so the decoder is shared between both sources.
  assign dec_code = (state_q == S_SCAN) ? cur_inc : in_sel;
  assign len_m1   = (in_len == '0) ? '0 : in_len - LEN_W'(1);

  dec_onehot_comb #(
    .NUM_OUT(NUM_OUT)
  ) u_dec (
    .code     (dec_code),
    .onehot   (dec_word),
    .range_err(dec_err)
  );

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cur_d      = cur_q;
    rem_d      = rem_q;
    err_beat_d = err_beat_q;
    if (state_q == S_SCAN) begin
      if (consume) begin
        cur_d = cur_inc;
        out_d = dec_word;
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = S_BEAT;
        end
      end
    end else if (accept) begin
      out_d      = dec_word;
      err_beat_d = dec_err;
      rem_d      = '0;
      state_d    = S_BEAT;
      // An out-of-range scan collapses to a single zero beat.
      if (!dec_err && (dec_mode_e'(in_mode) == DEC_MODE_SCAN)) begin
        cur_d = in_sel;
        rem_d = len_m1;
        if (len_m1 != '0) begin
          state_d = S_SCAN;
        end
      end
    end else if (consume) begin
      state_d    = S_IDLE;
      out_d      = '0;
      err_beat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      out_q      <= '0;
      cur_q      <= '0;
      rem_q      <= '0;
      err_beat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      cur_q      <= cur_d;
      rem_q      <= rem_d;
      err_beat_q <= err_beat_d;
    end
  end

  assign out = out_q;

`ifdef DEC_ERR_STICKY_EN
  logic err_q;
  logic unused_err_beat;
  assign unused_err_beat = err_beat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && dec_err) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = out_valid && err_beat_q;
`endif

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed self-checking bench: an 8-output instance for decode/scan and a 6-output one for range errors.
module tb_dec_onehot_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-output instance
  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_err, a_err_clr;
  logic [2:0] a_in_sel;
  logic [3:0] a_in_len;
  logic [7:0] a_out;

  // 6-output instance
  logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_err, b_err_clr;
  logic [2:0] b_in_sel;
  logic [3:0] b_in_len;
  logic [5:0] b_out;

  int n_cmp = 0;
  int n_mis = 0;

  dec_onehot_seq #(.NUM_OUT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_mode(a_in_mode), .in_len(a_in_len), .out(a_out),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .err(a_err), .err_clr(a_err_clr)
  );

  dec_onehot_seq #(.NUM_OUT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_mode(b_in_mode), .in_len(b_in_len), .out(b_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .err(b_err), .err_clr(b_err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] scan_exp [4];
  logic       rdy_exp  [4];
  bit         sticky;

  initial begin
`ifdef DEC_ERR_STICKY_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    scan_exp = '{8'h40, 8'h80, 8'h01, 8'h02};
    rdy_exp  = '{1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    a_in_valid = 0; a_in_sel = 0; a_in_mode = 0; a_in_len = 0; a_out_ready = 1; a_err_clr = 0;
    b_in_valid = 0; b_in_sel = 0; b_in_mode = 0; b_in_len = 0; b_out_ready = 1; b_err_clr = 0;
    step();
    step();
    check("rst_out", 64'(a_out), 64'h0);
    check("rst_valid", 64'(a_out_valid), 64'h0);
    check("rst_err", 64'(a_err), 64'h0);
    check("rst_out6", 64'(b_out), 64'h0);

    // Single decode of code 5
    rst_n = 1'b1;
    a_in_valid = 1; a_in_sel = 3'd5; a_in_mode = 0;
    #1;
    check("dec5_ready", 64'(a_in_ready), 64'h1);
    step();
    check("dec5_out", 64'(a_out), 64'h20);
    check("dec5_valid", 64'(a_out_valid), 64'h1);

    // Back-to-back decodes 0..7, no bubbles
    for (int i = 0; i < 8; i++) begin
      a_in_sel = 3'(i);
      #1;
      check("b2b_ready", 64'(a_in_ready), 64'h1);
      step();
      check("b2b_out", 64'(a_out), 64'd1 << i);
      check("b2b_valid", 64'(a_out_valid), 64'h1);
    end
    a_in_valid = 0;
    step();
    check("b2b_drain", 64'(a_out_valid), 64'h0);

    // Scan from 6, length 4, wraps past output 7
    a_in_valid = 1; a_in_sel = 3'd6; a_in_mode = 1; a_in_len = 4'd4;
    step();
    a_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check("scan_out", 64'(a_out), 64'(scan_exp[i]));
      check("scan_ready", 64'(a_in_ready), 64'(rdy_exp[i]));
      check("scan_valid", 64'(a_out_valid), 64'h1);
    end
    step();
    check("scan_done", 64'(a_out_valid), 64'h0);

    // Length 0 scan under backpressure: one beat, held while stalled
    a_out_ready = 0;
    a_in_valid = 1; a_in_sel = 3'd3; a_in_mode = 1; a_in_len = 4'd0;
    step();
    a_in_valid = 0;
    check("len0_out", 64'(a_out), 64'h08);
    check("len0_ready", 64'(a_in_ready), 64'h0);
    step();
    check("len0_hold", 64'(a_out), 64'h08);
    check("len0_hold_v", 64'(a_out_valid), 64'h1);
    a_out_ready = 1;
    step();
    check("len0_single", 64'(a_out_valid), 64'h0);

    // Length 5 scan interrupted by reset after two beats
    a_in_valid = 1; a_in_sel = 3'd2; a_in_mode = 1; a_in_len = 4'd5;
    step();
    a_in_valid = 0;
    check("rs_beat0", 64'(a_out), 64'h04);
    step();
    check("rs_beat1", 64'(a_out), 64'h08);
    rst_n = 1'b0;
    step();
    check("rs_out", 64'(a_out), 64'h0);
    check("rs_valid", 64'(a_out_valid), 64'h0);
    rst_n = 1'b1;
    step(); step(); step();
    check("rs_quiet", 64'(a_out_valid), 64'h0);
    check("rs_quiet_out", 64'(a_out), 64'h0);

    // 6-output: in-range scan wraps at 5
    b_in_valid = 1; b_in_sel = 3'd4; b_in_mode = 1; b_in_len = 4'd3;
    step();
    b_in_valid = 0;
    check("w6_b0", 64'(b_out), 64'h10);
    step();
    check("w6_b1", 64'(b_out), 64'h20);
    step();
    check("w6_b2", 64'(b_out), 64'h01);
    check("w6_err", 64'(b_err), 64'h0);
    step();
    check("w6_done", 64'(b_out_valid), 64'h0);

    // 6-output: out-of-range scan gives one zero beat with err
    b_out_ready = 0;
    b_in_valid = 1; b_in_sel = 3'd7; b_in_mode = 1; b_in_len = 4'd3;
    step();
    b_in_valid = 0;
    check("rng_out", 64'(b_out), 64'h0);
    check("rng_valid", 64'(b_out_valid), 64'h1);
    check("rng_err", 64'(b_err), 64'h1);
    b_out_ready = 1;
    step();
    check("rng_single", 64'(b_out_valid), 64'h0);
    check("rng_err_after", 64'(b_err), 64'(sticky));
    step();
    check("rng_err_hold", 64'(b_err), 64'(sticky));
    b_err_clr = 1;
    step();
    b_err_clr = 0;
    check("rng_err_clr", 64'(b_err), 64'h0);

    // Clear and new out-of-range accept together: set wins
    b_err_clr = 1;
    b_in_valid = 1; b_in_sel = 3'd6; b_in_mode = 0;
    step();
    b_err_clr = 0; b_in_valid = 0;
    check("set_wins", 64'(b_err), 64'h1);
    check("set_wins_out", 64'(b_out), 64'h0);
    step();
    check("set_wins_done", 64'(b_out_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
